fused_ofm_writeback_unit: RTL and testbench

// - Store-side counterpart of the fused load path: global BRAM -> fused BRAMs carries weights/IFM in; this block carries layer-2 OFM back out.
// - Accepts the per-byte OFM stream from the fused block and packs it into LANES-byte words.
// - Buffers packed words in a small FIFO and writes them to global BRAM, from base_addr_OFM upward, when the shared write port is granted.
// - Pulses done once size_OFM bytes are committed.

---
 rtl/fused_pkg.sv | 22 ++
 rtl/fused_wb_fifo.sv | 60 ++++++
 rtl/fused_ofm_writeback_unit.sv | 181 ++++++++++++++++++
 tb/tb_fused_ofm_writeback_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fused_pkg.sv
// Shared types and constants for the fused OFM write-back path.
// Holds the write-back FSM encoding, the default element/lane geometry
// and a rounding-up divide used to reason about packed word counts.
package fused_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wb_state_t;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_LANES  = 16;

    // Number of den-sized words needed to hold num items; widened so that
    // sizes close to 2^32 do not overflow the intermediate sum.
    function automatic logic [31:0] ceil_div(input logic [31:0] num, input logic [31:0] den);
        return 32'((33'(num) + 33'(den) - 33'd1) / 33'(den));
    endfunction

endpackage

// File: rtl/fused_wb_fifo.sv
// Small synchronous FIFO buffering packed OFM words ahead of the global
// BRAM write port. First-word-fall-through: data_o always shows the head.
// Push is ignored when full and pop is ignored when empty.
module fused_wb_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rptr_q];

    // Storage array: written on push only.
    // NOTE: the data array is deliberately not reset; the pointers and count
    // define which entries are valid, so clearing storage would only cost
    // reset fan-out without changing behaviour.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping; depth is a power of two so the
    // pointers wrap naturally.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/fused_ofm_writeback_unit.sv
// Layer-2 OFM write-back: packs the per-byte OFM stream into LANES-byte
// words, buffers them, and writes them to global BRAM from base_addr_OFM
// upward whenever the shared write port is granted. Pulses done once all
// size_OFM bytes have been written.
// Build option OFM_BYTE_MASK_EN adds wr_be_global, a per-lane byte enable
// that marks the real bytes of a partial final word.
module fused_ofm_writeback_unit
    import fused_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int LANES      = DEFAULT_LANES,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr_OFM,
    input  logic [31:0]             size_OFM,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    in_ready,
    input  logic                    wr_gnt_global,
    output logic [ADDR_W-1:0]       wr_addr_global,
    output logic [LANES*DATA_W-1:0] wr_data_global,
    output logic                    we_global,
    output logic                    busy,
    output logic                    done
`ifdef OFM_BYTE_MASK_EN
    ,
    output logic [LANES-1:0]        wr_be_global
`endif
);

    localparam int WORD_W = LANES * DATA_W;
    localparam int LANE_W = $clog2(LANES);
`ifdef OFM_BYTE_MASK_EN
    localparam int FIFO_W = WORD_W + LANES;
`else
    localparam int FIFO_W = WORD_W;
`endif

    wb_state_t          state_q, state_d;
    logic [31:0]        size_q;
    logic [31:0]        byte_cnt_q;
    logic [LANE_W-1:0]  lane_q;
    logic [WORD_W-1:0]  pack_q, pack_d;
    logic [ADDR_W-1:0]  next_addr_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [WORD_W-1:0]  wr_data_q;
    logic               we_q;
    logic [FIFO_W-1:0]  fifo_din, fifo_dout;
    logic               fifo_full, fifo_empty, fifo_pop;
    logic               start_acc, accept, last_byte, push;

    assign start_acc = (state_q == IDLE) && start;
    assign in_ready  = (state_q == PACK) && !fifo_full;
    assign accept    = in_valid && in_ready;
    assign last_byte = accept && (byte_cnt_q + 32'd1 == size_q);
    assign push      = accept && ((lane_q == LANE_W'(LANES - 1)) || last_byte);
    assign fifo_pop  = wr_gnt_global && !fifo_empty;

    assign busy           = (state_q == PACK) || (state_q == DRAIN);
    assign done           = (state_q == DONE);
    assign we_global      = we_q;
    assign wr_addr_global = wr_addr_q;
    assign wr_data_global = wr_data_q;

    // Current partial word with the incoming byte dropped into its lane.
    // NOTE: combinational blocks assign a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        pack_d = pack_q;
        pack_d[int'(lane_q)*DATA_W +: DATA_W] = in_data;
    end

`ifdef OFM_BYTE_MASK_EN
    logic [LANES-1:0] mask_d;
    logic [LANES-1:0] wr_be_q;

    // Lanes 0..lane_q hold real bytes at the moment a word is pushed.
    always_comb begin
        mask_d = '0;
        for (int i = 0; i < LANES; i++) begin
            mask_d[i] = (i <= int'(lane_q));
        end
    end

    assign fifo_din     = {mask_d, pack_d};
    assign wr_be_global = wr_be_q;
`else
    assign fifo_din = pack_d;
`endif

    fused_wb_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .data_i  (fifo_din),
        .pop_i   (fifo_pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Job sequencing: a zero-size job goes straight to DONE; DRAIN waits
    // until the last buffered word has been popped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (size_OFM == 32'd0) ? DONE : PACK;
            PACK:    if (last_byte) state_d = DRAIN;
            DRAIN:   if (fifo_empty) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Packer: byte counter, lane index and the partially filled word,
    // which is cleared after every push so unfilled lanes read as zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            size_q     <= '0;
            byte_cnt_q <= '0;
            lane_q     <= '0;
            pack_q     <= '0;
        end else if (start_acc) begin
            size_q     <= size_OFM;
            byte_cnt_q <= '0;
            lane_q     <= '0;
            pack_q     <= '0;
        end else if (accept) begin
            byte_cnt_q <= byte_cnt_q + 32'd1;
            if (push) begin
                lane_q <= '0;
                pack_q <= '0;
            end else begin
                lane_q <= lane_q + 1'b1;
                pack_q <= pack_d;
            end
        end
    end

    // Write side: a pop registers the word, its address and the strobe for
    // exactly one cycle; the address walks upward and wraps silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q        <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            next_addr_q <= '0;
`ifdef OFM_BYTE_MASK_EN
            wr_be_q     <= '0;
`endif
        end else begin
            we_q <= fifo_pop;
            if (start_acc) begin
                next_addr_q <= base_addr_OFM;
            end else if (fifo_pop) begin
                next_addr_q <= next_addr_q + ADDR_W'(LANES);
            end
            if (fifo_pop) begin
                wr_addr_q <= next_addr_q;
                wr_data_q <= fifo_dout[WORD_W-1:0];
`ifdef OFM_BYTE_MASK_EN
                wr_be_q   <= fifo_dout[FIFO_W-1 -: LANES];
`endif
            end
        end
    end

endmodule

// File: tb/tb_fused_ofm_writeback_unit.sv
// Scoreboard bench for fused_ofm_writeback_unit: each job start pushes its
// expected writes; a negedge monitor pops and compares every strobe and
// checks done timing.
module tb_fused_ofm_writeback_unit;
    import fused_pkg::*;

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] data;
        logic [15:0]  be;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  base_addr_OFM = '0;
    logic [31:0]  size_OFM = '0;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data = '0;
    logic         in_ready;
    logic         wr_gnt_global = 1'b0;
    logic [31:0]  wr_addr_global;
    logic [127:0] wr_data_global;
    logic         we_global;
    logic         busy;
    logic         done;
`ifdef OFM_BYTE_MASK_EN
    logic [15:0]  wr_be_global;
`endif

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails = 0;
    int   cyc = 0;
    int   last_we_cyc = 0;
    int   start_edge = 0;
    int   done_cnt = 0;
    int   done_base = 0;
    bit   exp_writes = 1'b0;
    bit   prev_done = 1'b0;

    fused_ofm_writeback_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr_OFM  (base_addr_OFM),
        .size_OFM       (size_OFM),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .wr_gnt_global  (wr_gnt_global),
        .wr_addr_global (wr_addr_global),
        .wr_data_global (wr_data_global),
        .we_global      (we_global),
        .busy           (busy),
        .done           (done)
`ifdef OFM_BYTE_MASK_EN
        ,
        .wr_be_global   (wr_be_global)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int idx, input logic [7:0] off);
        return 8'(idx) + off;
    endfunction

    // Output monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (we_global) begin
            if (sb.size() == 0) begin
                check("unexpected_we", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                check("wr_addr", wr_addr_global, e.addr);
                check("wr_data", wr_data_global, e.data);
`ifdef OFM_BYTE_MASK_EN
                check("wr_be", wr_be_global, e.be);
`endif
            end
            last_we_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            check("done_pulse_width", prev_done, 1'b0);
            if (exp_writes) check("done_after_last_we", cyc - last_we_cyc, 1);
            else            check("done_after_start", (cyc - start_edge) <= 2, 1'b1);
            check("sb_drained_at_done", sb.size(), 0);
        end
        prev_done = done;
    end

    // Drives start for one cycle; optionally records the expected writes.
    task automatic start_job(input logic [31:0] base, input logic [31:0] size,
                             input logic [7:0] off, input bit record);
        exp_t e;
        int   nw;
        start         = 1'b1;
        base_addr_OFM = base;
        size_OFM      = size;
        start_edge    = cyc + 1;
        done_base     = done_cnt;
        exp_writes    = record && (size != 0);
        if (record) begin
            nw = int'(ceil_div(size, 32'd16));
            for (int w = 0; w < nw; w++) begin
                e.addr = base + 32'(w * 16);
                e.data = '0;
                e.be   = '0;
                for (int l = 0; l < 16; l++) begin
                    if (w * 16 + l < int'(size)) begin
                        e.data[l*8 +: 8] = pat(w * 16 + l, off);
                        e.be[l]          = 1'b1;
                    end
                end
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, size != 0);
    endtask

    // Offers bytes [from,to) one per cycle, honouring in_ready, for at most
    // budget cycles; returns how many were accepted.
    task automatic drive_bytes(input int from, input int to, input logic [7:0] off,
                               input int budget, output int got);
        int  idx = from;
        int  n = 0;
        bit  rdy;
        while (idx < to && n < budget) begin
            in_valid = 1'b1;
            in_data  = pat(idx, off);
            rdy      = in_ready;
            @(posedge clk);
            #1;
            if (rdy) idx++;
            n++;
        end
        in_valid = 1'b0;
        got = idx - from;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == done_base && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_seen", done_cnt != done_base, 1'b1);
        @(posedge clk);
        #1;
        check("idle_busy", busy, 1'b0);
        check("idle_done", done, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", we_global, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Two full words, continuous grant
        wr_gnt_global = 1'b1;
        start_job(32'h0000_1000, 32'd32, 8'h00, 1'b1);
        drive_bytes(0, 32, 8'h00, 100, got);
        check("t1_accepted", got, 32);
        wait_done(50);

        // Partial final word is zero padded
        start_job(32'h0000_2000, 32'd20, 8'h40, 1'b1);
        drive_bytes(0, 20, 8'h40, 100, got);
        check("t2_accepted", got, 20);
        wait_done(50);

        // Back-pressure while the write port is withheld
        wr_gnt_global = 1'b0;
        start_job(32'h0000_5000, 32'd96, 8'h80, 1'b1);
        drive_bytes(0, 96, 8'h80, 80, got);
        check("t3_accepted_until_full", got, 64);
        check("t3_in_ready_full", in_ready, 1'b0);
        check("t3_no_write_without_gnt", sb.size(), 6);
        wr_gnt_global = 1'b1;
        drive_bytes(64, 96, 8'h80, 200, got);
        check("t3_accepted_rest", got, 32);
        wait_done(50);

        // Zero-size job
        start_job(32'h0000_6000, 32'd0, 8'h00, 1'b1);
        wait_done(5);

        // start during PACK is ignored
        start_job(32'h0000_7000, 32'd32, 8'h20, 1'b1);
        drive_bytes(0, 8, 8'h20, 50, got);
        check("t5_first_part", got, 8);
        start         = 1'b1;
        base_addr_OFM = 32'h0000_9000;
        size_OFM      = 32'd16;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("t5_busy_kept", busy, 1'b1);
        drive_bytes(8, 32, 8'h20, 100, got);
        check("t5_second_part", got, 24);
        wait_done(50);

        // Reset mid-PACK aborts the job; no writes expected from it
        start_job(32'h0000_3000, 32'd32, 8'hC0, 1'b0);
        drive_bytes(0, 10, 8'hC0, 50, got);
        check("t6_partial", got, 10);
        reset_n = 1'b0;
        #1;
        check("t6_rst_we", we_global, 1'b0);
        check("t6_rst_addr", wr_addr_global, 32'h0);
        check("t6_rst_data", wr_data_global, 128'h0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_done", done, 1'b0);
        check("t6_rst_in_ready", in_ready, 1'b0);
`ifdef OFM_BYTE_MASK_EN
        check("t6_rst_be", wr_be_global, 16'h0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        start_job(32'h0000_4000, 32'd16, 8'hA0, 1'b1);
        drive_bytes(0, 16, 8'hA0, 50, got);
        check("t6_new_job", got, 16);
        wait_done(50);

        // Address wrap at the top of the space
        start_job(32'hFFFF_FFF0, 32'd32, 8'h55, 1'b1);
        drive_bytes(0, 32, 8'h55, 100, got);
        check("t7_accepted", got, 32);
        wait_done(50);

        check("final_sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
